// File: rtl/branch_pc_sequencer.sv
// PC owner for the 5-stage MIPS core: next-PC selection, squash flushes,
// post-redirect branch shadow, HALT handling and saturating branch statistics.
module branch_pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              SHADOW   = 2,
    parameter int              CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             id_jump,
    input  logic [PC_W-1:0]  id_jump_target,
    input  logic             ex_branch,
    input  logic             ex_bne,
    input  logic             ex_zero,
    input  logic [PC_W-1:0]  ex_target,
    output logic [PC_W-1:0]  pc,
    output logic [1:0]       pc_src,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int SH_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

    localparam logic [1:0] SRC_SEQ    = 2'd0;
    localparam logic [1:0] SRC_BRANCH = 2'd1;
    localparam logic [1:0] SRC_JUMP   = 2'd2;
    localparam logic [1:0] SRC_HOLD   = 2'd3;

    typedef enum logic [1:0] {S_RUN, S_SHADOW, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   shd_q, shd_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;
    logic [1:0]        src_c;
    logic              br_valid;
    logic              taken;

    assign br_valid = ex_branch & (shd_q == '0) & (state_q != S_HALT);
    assign taken    = br_valid & (ex_zero ^ ex_bne);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RUN;
            shd_q        <= '0;
            pc_q         <= RESET_PC;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else begin
            state_q      <= state_d;
            shd_q        <= shd_d;
            pc_q         <= pc_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    // Taken beats halt: the redirect lands and halt is retried next cycle.
    always_comb begin
        state_d = state_q;
        shd_d   = shd_q;
        if (state_q == S_HALT) begin
            shd_d = '0;
            if (resume) state_d = S_RUN;
        end else begin
            if (shd_q != '0) shd_d = shd_q - 1'b1;
            state_d = (shd_d != '0) ? S_SHADOW : S_RUN;
            if (taken) begin
                shd_d   = SH_W'(SHADOW);
                state_d = (SHADOW > 0) ? S_SHADOW : S_RUN;
            end else if (halt) begin
                shd_d   = '0;
                state_d = S_HALT;
            end
        end
    end

    always_comb begin
        src_c        = SRC_SEQ;
        pc_d         = pc_q;
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        if (state_q == S_HALT)  src_c = SRC_HOLD;
        else if (taken)         src_c = SRC_BRANCH;
        else if (stall)         src_c = SRC_HOLD;
        else if (id_jump)       src_c = SRC_JUMP;
        case (src_c)
            SRC_BRANCH: pc_d = ex_target;
            SRC_JUMP:   pc_d = id_jump_target;
            SRC_SEQ:    pc_d = pc_q + PC_W'(4);
            default:    pc_d = pc_q;
        endcase
        // Stall does not suppress counting; the branch did resolve this cycle.
        if (br_valid && cnt_branch_q != '1) cnt_branch_d = cnt_branch_q + 1'b1;
        if (taken && cnt_taken_q != '1)     cnt_taken_d  = cnt_taken_q + 1'b1;
    end

    // Decode-side outputs are forced quiet while reset is asserted.
    assign pc_src     = reset_n ? src_c : SRC_SEQ;
    assign flush_idex = reset_n & taken;
    assign flush_ifid = reset_n & (taken | (id_jump & ~stall & (state_q != S_HALT)));
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign cnt_branch = cnt_branch_q;
    assign cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: directed scenarios plus randomized cycles
// checked against a cycle-level reference model of the sequencing rules.
module tb_branch_pc_sequencer;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          SHADOW   = 2;
    localparam int          CNT_W    = 8;
    localparam int          MAXC     = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             stall = 0, halt = 0, resume = 0, id_jump = 0;
    logic [PC_W-1:0]  id_jump_target = '0;
    logic             ex_branch = 0, ex_bne = 0, ex_zero = 0;
    logic [PC_W-1:0]  ex_target = '0;
    logic [PC_W-1:0]  pc;
    logic [1:0]       pc_src;
    logic             flush_ifid, flush_idex, halted;
    logic [CNT_W-1:0] cnt_branch, cnt_taken;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [31:0] m_pc;
    int          m_shd, m_cb, m_ct;
    logic        m_halt;
    logic        e_bv, e_tk, e_fi, e_fe;
    logic [1:0]  e_src;

    branch_pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .SHADOW(SHADOW), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .halt(halt), .resume(resume),
        .id_jump(id_jump), .id_jump_target(id_jump_target), .ex_branch(ex_branch),
        .ex_bne(ex_bne), .ex_zero(ex_zero), .ex_target(ex_target), .pc(pc),
        .pc_src(pc_src), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halted(halted), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    always #5 clock = ~clock;

    always_comb begin
        e_bv  = reset_n && ex_branch && (m_shd == 0) && !m_halt;
        e_tk  = e_bv && (ex_zero != ex_bne);
        e_src = 2'd0;
        e_fi  = 1'b0;
        e_fe  = 1'b0;
        if (reset_n) begin
            if (m_halt) e_src = 2'd3;
            else begin
                if (e_tk)         e_src = 2'd1;
                else if (stall)   e_src = 2'd3;
                else if (id_jump) e_src = 2'd2;
                e_fe = e_tk;
                e_fi = e_tk || (id_jump && !stall);
            end
        end
    end

    task automatic model_reset;
        m_pc = RESET_PC; m_shd = 0; m_cb = 0; m_ct = 0; m_halt = 1'b0;
    endtask

    task automatic clear_inputs;
        stall = 0; halt = 0; resume = 0; id_jump = 0; ex_branch = 0;
        ex_bne = 0; ex_zero = 0;
    endtask

    // Advance one clock; the model consumes the inputs as seen before the edge.
    task automatic tick;
        logic bv, tk;
        logic [1:0] s;
        logic [31:0] jt, bt;
        logic h, r;
        bv = e_bv; tk = e_tk; s = e_src; jt = id_jump_target; bt = ex_target;
        h = halt; r = resume;
        @(posedge clock);
        if (reset_n) begin
            if (m_halt) begin
                if (r) m_halt = 1'b0;
                m_shd = 0;
            end else begin
                if (s == 2'd1)      m_pc = bt;
                else if (s == 2'd2) m_pc = jt;
                else if (s == 2'd0) m_pc = m_pc + 32'd4;
                if (bv && m_cb < MAXC) m_cb++;
                if (tk && m_ct < MAXC) m_ct++;
                if (tk) m_shd = SHADOW;
                else if (m_shd > 0) m_shd--;
                if (h && !tk) begin m_halt = 1'b1; m_shd = 0; end
            end
        end
        #1;
    endtask

    task automatic jump_to(input logic [31:0] t);
        id_jump = 1; id_jump_target = t;
        tick();
        id_jump = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
        n_checks++; if (cnt_branch !== 0 || cnt_taken !== 0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt_branch, cnt_taken); end
        n_checks++; if (halted !== 1'b0 || pc_src !== 2'd0) begin n_err++; $display("FAIL reset_flags halted=%b pc_src=%0d exp 0/0", halted, pc_src); end
        reset_n = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_checks++; if (pc_src !== 2'd0 || flush_ifid !== 0 || flush_idex !== 0) begin
                n_err++; $display("FAIL seq_src cyc%0d pc_src=%0d fl=%b%b exp 0 00", i, pc_src, flush_ifid, flush_idex); end
            tick();
            n_checks++; if (pc !== 32'(4*i)) begin n_err++; $display("FAIL seq_pc cyc%0d got=%h exp=%h", i, pc, 32'(4*i)); end
        end
    endtask

    task automatic test_branch_taken;
        ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_target = 32'h40;
        #1;
        n_checks++; if (flush_ifid !== 1 || flush_idex !== 1 || pc_src !== 2'd1) begin
            n_err++; $display("FAIL taken_flush fl=%b%b pc_src=%0d exp 11 1", flush_ifid, flush_idex, pc_src); end
        tick();
        n_checks++; if (pc !== 32'h40) begin n_err++; $display("FAIL taken_pc got=%h exp=40", pc); end
        n_checks++; if (cnt_branch !== 1 || cnt_taken !== 1) begin n_err++; $display("FAIL taken_cnt got=%0d/%0d exp=1/1", cnt_branch, cnt_taken); end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (flush_idex !== 0 || pc_src !== 2'd0) begin
                n_err++; $display("FAIL shadow_mask cyc%0d flush_idex=%b pc_src=%0d exp 0 0", i, flush_idex, pc_src); end
            tick();
        end
        n_checks++; if (pc !== 32'h48 || cnt_branch !== 1 || cnt_taken !== 1) begin
            n_err++; $display("FAIL shadow_after pc=%h cnt=%0d/%0d exp 48 1/1", pc, cnt_branch, cnt_taken); end
        clear_inputs();
    endtask

    task automatic test_not_taken;
        jump_to(32'h20);
        ex_branch = 1; ex_bne = 1; ex_zero = 1;
        #1;
        n_checks++; if (flush_idex !== 0 || pc_src !== 2'd0) begin n_err++; $display("FAIL bne_nt_src flush_idex=%b pc_src=%0d exp 0 0", flush_idex, pc_src); end
        tick();
        n_checks++; if (pc !== 32'h24 || cnt_branch !== 2 || cnt_taken !== 1) begin
            n_err++; $display("FAIL bne_nt pc=%h cnt=%0d/%0d exp 24 2/1", pc, cnt_branch, cnt_taken); end
        clear_inputs();
    endtask

    task automatic test_priority;
        ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_target = 32'h80;
        stall = 1; id_jump = 1; id_jump_target = 32'h200;
        #1;
        n_checks++; if (pc_src !== 2'd1 || flush_ifid !== 1) begin n_err++; $display("FAIL prio_src pc_src=%0d flush_ifid=%b exp 1 1", pc_src, flush_ifid); end
        tick();
        n_checks++; if (pc !== 32'h80) begin n_err++; $display("FAIL prio_pc got=%h exp=80", pc); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_stall_jump;
        jump_to(32'h30);
        stall = 1; id_jump = 1; id_jump_target = 32'h200;
        #1;
        n_checks++; if (pc_src !== 2'd3 || flush_ifid !== 0 || flush_idex !== 0) begin
            n_err++; $display("FAIL stall_src pc_src=%0d fl=%b%b exp 3 00", pc_src, flush_ifid, flush_idex); end
        tick();
        n_checks++; if (pc !== 32'h30) begin n_err++; $display("FAIL stall_hold got=%h exp=30", pc); end
        stall = 0;
        #1;
        n_checks++; if (pc_src !== 2'd2 || flush_ifid !== 1 || flush_idex !== 0) begin
            n_err++; $display("FAIL jump_src pc_src=%0d fl=%b%b exp 2 10", pc_src, flush_ifid, flush_idex); end
        tick();
        n_checks++; if (pc !== 32'h200) begin n_err++; $display("FAIL jump_pc got=%h exp=200", pc); end
        clear_inputs();
    endtask

    task automatic test_halt;
        int cb0, ct0;
        jump_to(32'h50);
        halt = 1;
        tick();
        halt = 0;
        n_checks++; if (halted !== 1 || pc !== 32'h54) begin n_err++; $display("FAIL halt_enter halted=%b pc=%h exp 1 54", halted, pc); end
        cb0 = int'(cnt_branch); ct0 = int'(cnt_taken);
        for (int i = 0; i < 5; i++) begin
            ex_branch = i[0]; ex_zero = 1; ex_bne = 0;
            #1;
            n_checks++; if (pc_src !== 2'd3 || flush_ifid !== 0 || flush_idex !== 0) begin
                n_err++; $display("FAIL halt_src cyc%0d pc_src=%0d fl=%b%b exp 3 00", i, pc_src, flush_ifid, flush_idex); end
            tick();
            n_checks++; if (pc !== 32'h54 || int'(cnt_branch) != cb0 || int'(cnt_taken) != ct0) begin
                n_err++; $display("FAIL halt_frozen cyc%0d pc=%h cnt=%0d/%0d exp 54 %0d/%0d", i, pc, cnt_branch, cnt_taken, cb0, ct0); end
        end
        clear_inputs();
        resume = 1;
        tick();
        resume = 0;
        n_checks++; if (halted !== 0 || pc !== 32'h54) begin n_err++; $display("FAIL resume halted=%b pc=%h exp 0 54", halted, pc); end
        tick();
        n_checks++; if (pc !== 32'h58) begin n_err++; $display("FAIL resume_next got=%h exp=58", pc); end
    endtask

    task automatic test_async_reset;
        ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_target = 32'h100;
        tick();
        #3;
        reset_n = 0;
        model_reset();
        #1;
        n_checks++; if (pc !== RESET_PC || cnt_branch !== 0 || cnt_taken !== 0 || halted !== 0) begin
            n_err++; $display("FAIL async_reset pc=%h cnt=%0d/%0d halted=%b exp 0 0/0 0", pc, cnt_branch, cnt_taken, halted); end
        n_checks++; if (pc_src !== 0 || flush_ifid !== 0 || flush_idex !== 0) begin
            n_err++; $display("FAIL async_reset_out pc_src=%0d fl=%b%b exp 0 00", pc_src, flush_ifid, flush_idex); end
        @(posedge clock);
        #2;
        reset_n = 1;
        ex_target = 32'h300;
        #1;
        n_checks++; if (flush_idex !== 1) begin n_err++; $display("FAIL post_reset_branch flush_idex=%b exp 1", flush_idex); end
        tick();
        n_checks++; if (pc !== 32'h300 || cnt_branch !== 1 || cnt_taken !== 1) begin
            n_err++; $display("FAIL post_reset_pc pc=%h cnt=%0d/%0d exp 300 1/1", pc, cnt_branch, cnt_taken); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_wrap;
        jump_to(32'hFFFF_FFFC);
        tick();
        n_checks++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap got=%h exp=0", pc); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            halt           = ($urandom_range(0, 15) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            id_jump        = ($urandom_range(0, 4) == 0);
            id_jump_target = $urandom & 32'hFFFF_FFFC;
            ex_branch      = ($urandom_range(0, 1) == 1);
            ex_bne         = 1'($urandom);
            ex_zero        = 1'($urandom);
            ex_target      = $urandom & 32'hFFFF_FFFC;
            #1;
            n_checks++; if (pc_src !== e_src || flush_ifid !== e_fi || flush_idex !== e_fe) begin
                n_err++; $display("FAIL rand_comb cyc%0d pc_src=%0d fl=%b%b exp %0d %b%b", i, pc_src, flush_ifid, flush_idex, e_src, e_fi, e_fe); end
            tick();
            n_checks++; if (pc !== m_pc || halted !== m_halt || int'(cnt_branch) != m_cb || int'(cnt_taken) != m_ct) begin
                n_err++; $display("FAIL rand_state cyc%0d pc=%h h=%b cnt=%0d/%0d exp %h %b %0d/%0d",
                                  i, pc, halted, cnt_branch, cnt_taken, m_pc, m_halt, m_cb, m_ct); end
        end
        clear_inputs();
        resume = 1;
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_saturation;
        for (int i = 0; i < MAXC + 10; i++) begin
            ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_target = 32'(i * 16);
            tick();
            ex_branch = 0;
            tick(); tick();
        end
        n_checks++; if (int'(cnt_taken) != MAXC || int'(cnt_branch) != MAXC) begin
            n_err++; $display("FAIL saturate cnt=%0d/%0d exp %0d/%0d", cnt_branch, cnt_taken, MAXC, MAXC); end
        ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_target = 32'h1000;
        #1;
        n_checks++; if (flush_idex !== 1) begin n_err++; $display("FAIL sat_taken flush_idex=%b exp 1", flush_idex); end
        tick();
        n_checks++; if (int'(cnt_taken) != MAXC || int'(cnt_branch) != MAXC || pc !== 32'h1000) begin
            n_err++; $display("FAIL sat_hold cnt=%0d/%0d pc=%h exp %0d/%0d 1000", cnt_branch, cnt_taken, pc, MAXC, MAXC); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch_taken();
        test_not_taken();
        test_priority();
        test_stall_jump();
        test_halt();
        test_async_reset();
        test_wrap();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
